// File: rtl/pipe_hold_pkg.sv
// Shared types and constants for the pipeline hold controller.
package pipe_hold_pkg;

  typedef enum logic [1:0] {
    PD_RUN,
    PD_DRAIN,
    PD_SLEEP
  } pd_state_t;

  // Stage indices for the default four-stage pipe.
  localparam int unsigned STG_D = 0;
  localparam int unsigned STG_R = 1;
  localparam int unsigned STG_E = 2;
  localparam int unsigned STG_C = 3;

endpackage

// File: rtl/pipe_hold_perf_cnt.sv
// Saturating stall counter with synchronous clear taking priority over increment.
module pipe_hold_perf_cnt #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_hold_ctl.sv
// Merges hold sources into per-stage pipe holds, with powerdown drain/sleep and stall counters.
module pipe_hold_ctl
  import pipe_hold_pkg::*;
#(
  parameter int unsigned NUM_SRC = 12,
  parameter int unsigned NUM_STG = 4,
  parameter int unsigned CNT_W   = 16,
  localparam int unsigned SEL_W  = (NUM_STG > 1) ? $clog2(NUM_STG) : 1
) (
  input  logic                       clk,
  input  logic                       reset_l,
  input  logic [NUM_SRC-1:0]         hold_src,
  input  logic [NUM_SRC*NUM_STG-1:0] src_mask,
  input  logic [NUM_SRC-1:0]         src_dly,
  input  logic                       pd_req,
  input  logic                       pd_wake,
  input  logic                       perf_clr,
  input  logic [SEL_W-1:0]           perf_sel,
  output logic [NUM_STG-1:0]         hold_stg,
  output logic [NUM_STG-1:0]         hold_stg_q,
  output logic                       pd_ack,
  output logic [CNT_W-1:0]           perf_cnt
);

  localparam logic [SEL_W-1:0] DRAIN_LOAD = SEL_W'(NUM_STG - 1);

  pd_state_t          state_q;
  logic [SEL_W-1:0]   drain_cnt_q;
  logic [NUM_SRC-1:0] src_q;
  logic [NUM_SRC-1:0] eff;
  logic [NUM_STG-1:0] raw_src;
  logic [NUM_STG-1:0] raw;
  logic [NUM_STG-1:0] pd_hold;
  logic [CNT_W-1:0]   cnt [NUM_STG];

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      src_q      <= '0;
      hold_stg_q <= '0;
    end else begin
      src_q      <= hold_src;
      hold_stg_q <= hold_stg;
    end
  end

  assign eff = (src_dly & src_q) | (~src_dly & hold_src);

  always_comb begin
    logic acc;
    raw_src = '0;
    for (int s = 0; s < NUM_STG; s++) begin
      acc = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
        acc = acc | (eff[i] & src_mask[i*NUM_STG+s]);
      end
      raw_src[s] = acc;
    end
  end

  always_comb begin
    pd_hold = '0;
    case (state_q)
      PD_DRAIN: pd_hold[0] = 1'b1;
      PD_SLEEP: pd_hold    = '1;
      default:  pd_hold    = '0;
    endcase
  end

  assign raw = raw_src | pd_hold;

  // A held stage holds every earlier stage behind it.
  always_comb begin
    logic acc;
    acc      = 1'b0;
    hold_stg = '0;
    for (int s = NUM_STG - 1; s >= 0; s--) begin
      acc         = acc | raw[s];
      hold_stg[s] = acc;
    end
  end

  // Drain counts only cycles where the last stage is free to retire.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q     <= PD_RUN;
      drain_cnt_q <= '0;
      pd_ack      <= 1'b0;
    end else begin
      case (state_q)
        PD_RUN: begin
          pd_ack <= 1'b0;
          if (pd_req) begin
            state_q     <= PD_DRAIN;
            drain_cnt_q <= DRAIN_LOAD;
          end
        end
        PD_DRAIN: begin
          if (pd_wake) begin
            state_q     <= PD_RUN;
            drain_cnt_q <= '0;
          end else if (!raw_src[NUM_STG-1]) begin
            if (drain_cnt_q <= SEL_W'(1)) begin
              state_q     <= PD_SLEEP;
              drain_cnt_q <= '0;
              pd_ack      <= 1'b1;
            end else begin
              drain_cnt_q <= drain_cnt_q - SEL_W'(1);
            end
          end
        end
        PD_SLEEP: begin
          if (pd_wake) begin
            state_q <= PD_RUN;
            pd_ack  <= 1'b0;
          end
        end
        default: begin
          state_q     <= PD_RUN;
          drain_cnt_q <= '0;
          pd_ack      <= 1'b0;
        end
      endcase
    end
  end

  for (genvar s = 0; s < NUM_STG; s++) begin : g_cnt
    pipe_hold_perf_cnt #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk    (clk),
      .reset_l(reset_l),
      .inc    (hold_stg[s]),
      .clr    (perf_clr),
      .cnt    (cnt[s])
    );
  end

  // Out-of-range selects match no stage and read as zero.
  always_comb begin
    perf_cnt = '0;
    for (int s = 0; s < NUM_STG; s++) begin
      if (perf_sel == SEL_W'(s)) perf_cnt = cnt[s];
    end
  end

endmodule

// File: tb/tb_pipe_hold_ctl.sv
// Self-checking bench for pipe_hold_ctl: routing table, delayed source, powerdown and counters.
module tb_pipe_hold_ctl;

  logic        clk = 1'b0;
  logic        reset_l;
  logic [11:0] hold_src;
  logic [47:0] src_mask;
  logic [11:0] src_dly;
  logic        pd_req;
  logic        pd_wake;
  logic        perf_clr;
  logic [1:0]  perf_sel;
  logic [3:0]  hold_stg;
  logic [3:0]  hold_stg_q;
  logic        pd_ack;
  logic [3:0]  perf_cnt;

  pipe_hold_ctl #(
    .NUM_SRC(12),
    .NUM_STG(4),
    .CNT_W  (4)
  ) dut (
    .clk       (clk),
    .reset_l   (reset_l),
    .hold_src  (hold_src),
    .src_mask  (src_mask),
    .src_dly   (src_dly),
    .pd_req    (pd_req),
    .pd_wake   (pd_wake),
    .perf_clr  (perf_clr),
    .perf_sel  (perf_sel),
    .hold_stg  (hold_stg),
    .hold_stg_q(hold_stg_q),
    .pd_ack    (pd_ack),
    .perf_cnt  (perf_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] hold;
    logic [3:0] hold_q;
    logic       ack;
    bit         use_perf;
    logic [3:0] perf;
  } exp_t;

  typedef struct {
    logic [11:0] src;
    logic [47:0] mask;
    logic [3:0]  hold;
  } vec_t;

  exp_t       sb[$];
  vec_t       vecs[10];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] last_hold = '0;

  task automatic push(string n, logic [3:0] h, logic [3:0] hq, logic a, bit up, logic [3:0] p);
    exp_t e;
    e.name = n; e.hold = h; e.hold_q = hq; e.ack = a; e.use_perf = up; e.perf = p;
    sb.push_back(e);
  endtask

  task automatic check_now();
    exp_t e;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      if (hold_stg !== e.hold || hold_stg_q !== e.hold_q || pd_ack !== e.ack ||
          (e.use_perf && perf_cnt !== e.perf)) begin
        errors++;
        $display("FAIL %s: got hold=%b hold_q=%b ack=%b perf=%0d, want hold=%b hold_q=%b ack=%b perf=%0d%s",
                 e.name, hold_stg, hold_stg_q, pd_ack, perf_cnt, e.hold, e.hold_q, e.ack, e.perf,
                 e.use_perf ? "" : " (perf unchecked)");
      end
    end
  endtask

  // One cycle: expectations queued with the stimulus, compared mid-cycle.
  task automatic cyc(string n, logic [3:0] h, logic a, bit up = 1'b0, logic [3:0] p = '0);
    push(n, h, last_hold, a, up, p);
    @(negedge clk);
    check_now();
    last_hold = h;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{12'h000, 48'hFFFF_FFFF_FFFF, 4'b0000};
    vecs[1] = '{12'h008, 48'h0000_0000_4000, 4'b0111};
    vecs[2] = '{12'h000, 48'h0000_0000_4000, 4'b0000};
    vecs[3] = '{12'h001, 48'h0000_0000_0001, 4'b0001};
    vecs[4] = '{12'h800, 48'h8000_0000_0000, 4'b1111};
    vecs[5] = '{12'h080, 48'h0000_2000_0000, 4'b0011};
    vecs[6] = '{12'h080, 48'h0000_0F00_0000, 4'b0000};
    vecs[7] = '{12'h204, 48'h0040_0000_0100, 4'b0111};
    vecs[8] = '{12'h010, 48'h0000_0003_0000, 4'b0011};
    vecs[9] = '{12'hFFF, 48'h0000_0000_0000, 4'b0000};

    reset_l = 1'b0; hold_src = '0; src_mask = '0; src_dly = '0;
    pd_req = 1'b0; pd_wake = 1'b0; perf_clr = 1'b0; perf_sel = 2'd0;

    repeat (2) @(posedge clk);
    #1;
    push("reset_state", 4'b0000, 4'b0000, 1'b0, 1'b1, 4'd0);
    check_now();
    reset_l = 1'b1;
    last_hold = '0;

    for (int i = 0; i < 10; i++) begin
      hold_src = vecs[i].src;
      src_mask = vecs[i].mask;
      cyc($sformatf("route%0d", i), vecs[i].hold, 1'b0);
    end

    hold_src = '0; src_mask = '0;
    cyc("idle", 4'b0000, 1'b0);
    src_dly = 12'h020; src_mask = 48'h0000_0080_0000;
    cyc("dly_pre", 4'b0000, 1'b0);
    hold_src[5] = 1'b1;
    cyc("dly_src", 4'b0000, 1'b0);
    hold_src = '0;
    cyc("dly_out", 4'b1111, 1'b0);
    cyc("dly_post", 4'b0000, 1'b0);
    src_dly = '0; src_mask = '0;

    pd_req = 1'b1;
    cyc("pd_req", 4'b0000, 1'b0);
    pd_req = 1'b0;
    for (int c = 1; c <= 3; c++) cyc("pd_drain", 4'b0001, 1'b0);
    for (int c = 4; c <= 8; c++) begin
      pd_req  = (c == 6);
      pd_wake = (c == 8);
      cyc("pd_sleep", 4'b1111, 1'b1);
    end
    pd_req = 1'b0; pd_wake = 1'b0;
    cyc("pd_wake", 4'b0000, 1'b0);
    cyc("pd_run", 4'b0000, 1'b0);

    src_mask = 48'h0000_0000_0008;
    pd_req = 1'b1;
    cyc("stall_req", 4'b0000, 1'b0);
    pd_req = 1'b0;
    cyc("stall_d1", 4'b0001, 1'b0);
    hold_src[0] = 1'b1;
    cyc("stall_h1", 4'b1111, 1'b0);
    cyc("stall_h2", 4'b1111, 1'b0);
    hold_src = '0;
    cyc("stall_d2", 4'b0001, 1'b0);
    cyc("stall_d3", 4'b0001, 1'b0);
    cyc("stall_sleep", 4'b1111, 1'b1);
    pd_wake = 1'b1;
    cyc("stall_wake", 4'b1111, 1'b1);
    pd_wake = 1'b0;
    cyc("stall_run", 4'b0000, 1'b0);
    src_mask = '0;

    pd_req = 1'b1;
    cyc("wr_req", 4'b0000, 1'b0);
    pd_req = 1'b0;
    cyc("wr_drain", 4'b0001, 1'b0);
    pd_req = 1'b1; pd_wake = 1'b1;
    cyc("wr_both", 4'b0001, 1'b0);
    pd_req = 1'b0; pd_wake = 1'b0;
    for (int c = 0; c < 4; c++) cyc("wr_stay_run", 4'b0000, 1'b0);

    pd_req = 1'b1;
    cyc("wd_req", 4'b0000, 1'b0);
    pd_req = 1'b0;
    cyc("wd_drain1", 4'b0001, 1'b0);
    cyc("wd_drain2", 4'b0001, 1'b0);
    pd_wake = 1'b1;
    cyc("wd_last", 4'b0001, 1'b0);
    pd_wake = 1'b0;
    cyc("wd_run", 4'b0000, 1'b0);
    cyc("wd_stay", 4'b0000, 1'b0);

    src_mask = 48'h0000_0000_0002; perf_sel = 2'd1; perf_clr = 1'b1;
    cyc("cnt_clr", 4'b0000, 1'b0);
    perf_clr = 1'b0;
    hold_src[0] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      cyc("cnt_sat", 4'b0011, 1'b0, 1'b1, 4'((k > 16) ? 15 : k - 1));
    end
    perf_clr = 1'b1;
    cyc("cnt_clr_held", 4'b0011, 1'b0, 1'b1, 4'd15);
    perf_clr = 1'b0;
    cyc("cnt_zero", 4'b0011, 1'b0, 1'b1, 4'd0);
    cyc("cnt_resume", 4'b0011, 1'b0, 1'b1, 4'd1);
    perf_sel = 2'd2;
    cyc("cnt_sel2", 4'b0011, 1'b0, 1'b1, 4'd0);
    perf_sel = 2'd0;
    cyc("cnt_sel0", 4'b0011, 1'b0, 1'b1, 4'd3);
    hold_src = '0; src_mask = '0;

    pd_req = 1'b1;
    cyc("ar_req", 4'b0000, 1'b0);
    pd_req = 1'b0;
    for (int c = 1; c <= 3; c++) cyc("ar_drain", 4'b0001, 1'b0);
    cyc("ar_sleep", 4'b1111, 1'b1);
    #2;
    reset_l = 1'b0;
    #1;
    for (int s = 0; s < 4; s++) begin
      perf_sel = 2'(s);
      #1;
      push($sformatf("ar_async_sel%0d", s), 4'b0000, 4'b0000, 1'b0, 1'b1, 4'd0);
      check_now();
    end
    @(posedge clk);
    #1;
    reset_l = 1'b1;
    last_hold = '0;
    perf_sel = 2'd1;
    cyc("ar_post", 4'b0000, 1'b0, 1'b1, 4'd0);
    cyc("ar_post2", 4'b0000, 1'b0, 1'b1, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
